// File: rtl/store_pkg.sv
// store_pkg
// Shared definitions for the store path: request size encodings, the
// store FSM state type and the per-size byte-enable masks before lane
// placement.
package store_pkg;

  // Request size encodings as presented on req_size.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Byte-enable masks for a value sitting in the lowest lanes.
  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  // Store sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/store_lane_packer.sv
// store_lane_packer
// Combinational narrowing and little-endian lane placement of a store value.
// The result spans two words so an unaligned access can be split into a
// low beat (window_o[31:0], be_o[3:0]) and a high beat (window_o[63:32],
// be_o[7:4]).
// Ports:
//   data_i   - register value to store
//   size_i   - size encoding (byte/half/word/illegal)
//   off_i    - byte offset within the word (address bits [1:0])
//   window_o - 64-bit lane-placed data window
//   be_o     - 8-bit byte enables matching window_o
module store_lane_packer
  import store_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  output logic [63:0] window_o,
  output logic [7:0]  be_o
);

  logic [31:0] narrowed;
  logic [3:0]  mask;

  // Keep only the bytes the requested width uses; an illegal size produces
  // no data and no enables so it can never reach memory.
  always_comb begin
    narrowed = 32'h0;
    mask     = MASK_NONE;
    case (size_i)
      SZ_BYTE: begin
        narrowed = {24'h0, data_i[7:0]};
        mask     = MASK_BYTE;
      end
      SZ_HALF: begin
        narrowed = {16'h0, data_i[15:0]};
        mask     = MASK_HALF;
      end
      SZ_WORD: begin
        narrowed = data_i;
        mask     = MASK_WORD;
      end
      default: begin
        narrowed = 32'h0;
        mask     = MASK_NONE;
      end
    endcase
  end

  // Shift into place across the two-word window; anything pushed past
  // bit 31 / enable bit 3 belongs to the second beat.
  assign window_o = {32'h0, narrowed} << {off_i, 3'b000};
  assign be_o     = {4'b0000, mask} << off_i;

endmodule

// File: rtl/store_unit.sv
// store_unit
// Store-path data mover: captures a store request, narrows and lane-places
// the value, and writes it to data memory over a valid/ready port, splitting
// word-crossing accesses into two word-aligned beats.
// Ports:
//   clk, rst_n            - clock and synchronous active-low reset
//   req_valid/req_ready   - request handshake (ready only when idle)
//   req_addr/data/size    - byte address, register value, size encoding
//   mem_valid/mem_ready   - memory write beat handshake
//   mem_addr/wdata/be     - word-aligned address, placed data, byte enables
//   done                  - one-cycle pulse when a store completes
//   err                   - one-cycle pulse (with done) for an illegal size
module store_unit
  import store_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_data,
  input  logic [1:0]    req_size,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  output logic          done,
  output logic          err
);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [1:0]    size_q, size_d;
  logic          ill_q, ill_d;

  logic [63:0]   window;
  logic [7:0]    be8;
  logic          split;
  logic [AW-1:0] beat0Addr;
  logic [AW-1:0] beat1Addr;

  // Placement works from the captured request so beat outputs stay stable
  // for as long as memory stalls.
  store_lane_packer u_packer (
    .data_i   (data_q),
    .size_i   (size_q),
    .off_i    (addr_q[1:0]),
    .window_o (window),
    .be_o     (be8)
  );

  assign split     = |be8[7:4];
  assign beat0Addr = {addr_q[AW-1:2], 2'b00};
  assign beat1Addr = beat0Addr + {{(AW-3){1'b0}}, 3'd4};

  // Next-state logic: capture on acceptance in IDLE, advance beats on
  // memory handshake, and always spend exactly one cycle in DONE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    ill_d   = ill_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_data;
          size_d  = req_size;
          ill_d   = (req_size == SZ_ILL);
          state_d = (req_size == SZ_ILL) ? ST_DONE : ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (mem_ready) begin
          state_d = split ? ST_BEAT1 : ST_DONE;
        end
      end
      ST_BEAT1: begin
        if (mem_ready) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ill_d   = 1'b0;
      end
    endcase
  end

  // State and request registers; reset drops any pending beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= 32'h0;
      size_q  <= SZ_BYTE;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      ill_q   <= ill_d;
    end
  end

  // Outputs decode from the registered state only; memory-side outputs are
  // forced to zero whenever no beat is being presented.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    done      = (state_q == ST_DONE);
    err       = (state_q == ST_DONE) && ill_q;
    case (state_q)
      ST_BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = beat0Addr;
        mem_wdata = window[31:0];
        mem_be    = be8[3:0];
      end
      ST_BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = beat1Addr;
        mem_wdata = window[63:32];
        mem_be    = be8[7:4];
      end
      default: begin
        mem_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit
// Directed self-checking bench for store_unit. Inputs change and outputs
// are sampled on the falling clock edge, away from the active rising edge.
module tb_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        err;

  int checkCount;
  int passCount;

  store_unit #(.AW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .done      (done),
    .err       (err)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  // Presents one request for a single rising edge, then withdraws it.
  // Returns in the cycle right after acceptance (T+1).
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] size);
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    req_size  = size;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF;
    req_data  = 32'hCAFE_F00D;
    req_size  = 2'b10;
  endtask

  // Checks the full memory-side beat presentation in one go.
  task automatic checkBeat(input string tag, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    checkOutput({tag, ".valid"}, {63'h0, mem_valid}, 64'h1);
    checkOutput({tag, ".addr"},  {32'h0, mem_addr},  {32'h0, addr});
    checkOutput({tag, ".wdata"}, {32'h0, mem_wdata}, {32'h0, wdata});
    checkOutput({tag, ".be"},    {60'h0, mem_be},    {60'h0, be});
    checkOutput({tag, ".rdy"},   {63'h0, req_ready}, 64'h0);
    checkOutput({tag, ".done"},  {63'h0, done},      64'h0);
  endtask

  // Checks the idle/reset-style quiet output state.
  task automatic checkQuiet(input string tag, input logic expDone, input logic expErr,
                            input logic expReady);
    checkOutput({tag, ".valid"}, {63'h0, mem_valid}, 64'h0);
    checkOutput({tag, ".addr"},  {32'h0, mem_addr},  64'h0);
    checkOutput({tag, ".wdata"}, {32'h0, mem_wdata}, 64'h0);
    checkOutput({tag, ".be"},    {60'h0, mem_be},    64'h0);
    checkOutput({tag, ".done"},  {63'h0, done},      {63'h0, expDone});
    checkOutput({tag, ".err"},   {63'h0, err},       {63'h0, expErr});
    checkOutput({tag, ".rdy"},   {63'h0, req_ready}, {63'h0, expReady});
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_data   = 32'h0;
    req_size   = 2'b00;
    mem_ready  = 1'b1;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkQuiet("reset", 1'b0, 1'b0, 1'b1);

    // SB at offset 3: single beat in the top lane.
    applyStimulus(32'h0000_1003, 32'hAABB_CCDD, 2'b00);
    checkBeat("sb.b0", 32'h0000_1000, 32'hDD00_0000, 4'b1000);
    @(negedge clk);
    checkQuiet("sb.done", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkQuiet("sb.idle", 1'b0, 1'b0, 1'b1);

    // SH at offset 3: crosses into the next word.
    applyStimulus(32'h0000_2003, 32'h1234_5678, 2'b01);
    checkBeat("sh.b0", 32'h0000_2000, 32'h7800_0000, 4'b1000);
    @(negedge clk);
    checkBeat("sh.b1", 32'h0000_2004, 32'h0000_0056, 4'b0001);
    @(negedge clk);
    checkQuiet("sh.done", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkQuiet("sh.idle", 1'b0, 1'b0, 1'b1);

    // SW near the top of the address space: beat 1 wraps to zero.
    applyStimulus(32'hFFFF_FFFE, 32'h1122_3344, 2'b10);
    checkBeat("swrap.b0", 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
    @(negedge clk);
    checkBeat("swrap.b1", 32'h0000_0000, 32'h0000_1122, 4'b0011);
    @(negedge clk);
    checkQuiet("swrap.done", 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Aligned SW with memory stalling for three cycles.
    mem_ready = 1'b0;
    applyStimulus(32'h0000_0010, 32'hCAFE_BABE, 2'b10);
    for (int i = 0; i < 3; i++) begin
      checkBeat("stall.b0", 32'h0000_0010, 32'hCAFE_BABE, 4'b1111);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    checkBeat("stall.hs", 32'h0000_0010, 32'hCAFE_BABE, 4'b1111);
    @(negedge clk);
    checkQuiet("stall.done", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkQuiet("stall.idle", 1'b0, 1'b0, 1'b1);

    // Illegal size: no beat, done and err together, then ready again.
    applyStimulus(32'h0000_3000, 32'h5555_AAAA, 2'b11);
    checkQuiet("ill.done", 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkQuiet("ill.idle", 1'b0, 1'b0, 1'b1);

    // Reset while beat 1 is waiting for memory.
    applyStimulus(32'h0000_2003, 32'h1234_5678, 2'b01);
    checkBeat("rst.b0", 32'h0000_2000, 32'h7800_0000, 4'b1000);
    @(negedge clk);
    mem_ready = 1'b0;
    checkBeat("rst.b1", 32'h0000_2004, 32'h0000_0056, 4'b0001);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    checkQuiet("rst.after", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkQuiet("rst.nodone", 1'b0, 1'b0, 1'b1);

    // Back-to-back byte store right after reset recovery.
    applyStimulus(32'h0000_0005, 32'h0000_00EE, 2'b00);
    checkBeat("sb1.b0", 32'h0000_0004, 32'h0000_EE00, 4'b0010);
    @(negedge clk);
    checkQuiet("sb1.done", 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/store_unit.md
# store_unit

Store-path data mover for the single-cycle-plus-memory CPU datapath. It accepts a store request (byte, halfword or word plus a 32-bit register value) and narrows the value to the requested width. It places the value in the correct little-endian byte lanes and generates byte enables. It then drives the data-memory write port with a valid/ready handshake, splitting any access that crosses a word boundary into two word-aligned beats. It is the write-direction counterpart of the load-side width extension: narrowing and lane placement instead of sign/zero extension.

## Interface
- AW, 32, address width in bits; addresses wrap modulo 2^AW.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  store request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  AW  byte address; any alignment is legal.
- req_data  in  32  register value; only the low byte or halfword is used for SB or SH.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- mem_valid  out  1  write beat valid.
- mem_ready  in  1  memory accepts the beat.
- mem_addr  out  AW  word-aligned address; [1:0] is always 0.
- mem_wdata  out  32  lane-placed write data.
- mem_be  out  4  byte enables; bit i enables mem_wdata[8i+7:8i].
- done  out  1  one-cycle pulse when a store has fully completed.
- err  out  1  one-cycle pulse when an illegal-size request is accepted.

## Operation
- A request is accepted when req_valid and req_ready are both high. On acceptance, addr, data and size are captured.
- Narrowing:
  - byte uses data[7:0], mask 0001;
  - half uses data[15:0], mask 0011;
  - word uses data[31:0], mask 1111.
- Lane placement: with off = addr[1:0], the 64-bit window is narrowed_data << (8*off) and the 8-bit enable is mask << off.
- Beat 0 uses window[31:0] and be[3:0] at address {addr[AW-1:2],2'b00}.
- Beat 1 exists only if be[7:4] != 0. It uses window[63:32] and be[7:4] at beat-0 address + 4, wrapping modulo 2^AW.
- FSM states are IDLE, BEAT0, BEAT1 and DONE.
  - IDLE goes to BEAT0 on acceptance of a legal size.
  - IDLE goes to DONE on acceptance of size 11, with no memory beat and with err set.
  - BEAT0 goes to BEAT1 on handshake if a split is needed; otherwise it goes to DONE.
  - BEAT1 goes to DONE on handshake.
  - DONE always goes to IDLE.
- done is asserted while in DONE. err is asserted in DONE only for an illegal request. done and err are both high for that single cycle.
- mem_valid is high exactly in BEAT0 and BEAT1.
- mem_addr, mem_wdata and mem_be are stable while mem_valid is high and mem_ready is low.
- Outside BEAT states, mem_wdata, mem_be and mem_addr are held at 0.
- Request inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE, req_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, err=0.
- Accept in cycle T; mem_valid rises in T+1.
- Aligned store with mem_ready held high: beat in T+1, done in T+2, req_ready high again in T+3.
- Split store: beats in T+1 and T+2, done in T+3.
- Each cycle of mem_ready low adds one cycle of latency; there is no timeout.
- Back-to-back throughput: one aligned store every 3 cycles.
- Reset asserted mid-operation: the next cycle is IDLE with all outputs at their reset values. The pending beat is dropped and no done is issued.
- A beat-1 address past 2^AW-4 wraps to 0.

## Structure
- The shared package store_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD and SZ_ILL;
  - the state enum;
  - the per-size enable mask constants.
- Sub-module store_lane_packer is combinational. It takes data, size and off, and produces the 64-bit window and the 8-bit enable.
- The FSM and registers live in store_unit.

## Test plan
- SB, addr 0x00001003, data 0xAABBCCDD, mem_ready high -> one beat: addr 0x00001000, wdata 0xDD000000, be 1000; then a done pulse.
- SH, addr 0x00002003, data 0x12345678 -> two beats:
  - beat 0: addr 0x00002000, wdata 0x78000000, be 1000;
  - beat 1: addr 0x00002004, wdata 0x00000056, be 0001;
  - then a single done pulse.
- SW, addr 0xFFFFFFFE, data 0x11223344 -> two beats:
  - beat 0: addr 0xFFFFFFFC, wdata 0x33440000, be 1100;
  - beat 1: addr 0x00000000, wdata 0x00001122, be 0011.
- SW aligned at 0x00000010 with mem_ready low for 3 cycles -> mem_valid held 4 cycles, outputs stable, req_ready 0 throughout; done 1 cycle after the handshake.
- req_size 11 -> mem_valid never asserted; err and done pulse together at T+1; req_ready is back at T+2.
- rst_n low during the BEAT1 wait -> next cycle mem_valid=0, state IDLE, req_ready=1, no done.
